// File: rtl/mul_wb_arbiter_if.sv
// Writeback arbiter bus: ALU result input, multiplier issue/result input,
// register-file write port and the sticky protocol-error flag.
interface mul_wb_arbiter_if #(
    parameter int ARCH_LEN = 32
);
    logic                alu_valid;
    logic [4:0]          alu_rd;
    logic [ARCH_LEN-1:0] alu_data;
    logic                alu_stall;
    logic                mul_issue;
    logic                mul_issue_ready;
    logic                mul_valid;
    logic [4:0]          mul_rd;
    logic [ARCH_LEN-1:0] mul_data;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic [ARCH_LEN-1:0] wb_data;
    logic                wb_src;
    logic                proto_err;

    // Execute stage / environment side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mul_issue, mul_valid, mul_rd, mul_data,
        input  alu_stall, mul_issue_ready,
        input  wb_valid, wb_rd, wb_data, wb_src, proto_err
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mul_issue, mul_valid, mul_rd, mul_data,
        output alu_stall, mul_issue_ready,
        output wb_valid, wb_rd, wb_data, wb_src, proto_err
    );
endinterface

// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and pipelined multiplier
// results onto one registered register-file write port. Multiplier results
// that lose arbitration wait in a small FIFO; issue credits guarantee the FIFO
// never overflows, and a starvation counter eventually forces a FIFO drain
// by stalling the ALU for one cycle.
module mul_wb_arbiter #(
    parameter int ARCH_LEN       = 32,
    parameter int MUL_FIFO_DEPTH = 8,
    parameter int STARVE_LIMIT   = 8
) (
    input logic             clk,
    input logic             rst,
    mul_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(MUL_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so issue/return arithmetic can exceed the depth before saturation.
    localparam int CRD_W = CNT_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(MUL_FIFO_DEPTH);
    localparam logic [CRD_W-1:0] DEPTH_EXT_C = CRD_W'(MUL_FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C     = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]          rd;
        logic [ARCH_LEN-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_DRAIN  = 3'd1,
        SEL_ALU    = 3'd2,
        SEL_FIFO   = 3'd3,
        SEL_BYPASS = 3'd4
    } sel_t;

    // Registered state
    entry_t              mem_r [MUL_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    fifo_cnt_r;
    logic [CNT_W-1:0]    credit_cnt_r;
    logic [STV_W-1:0]    starve_cnt_r;
    logic                proto_err_r;
    logic                wb_valid_r;
    logic [4:0]          wb_rd_r;
    logic [ARCH_LEN-1:0] wb_data_r;
    logic                wb_src_r;

    // Combinational decisions
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic                force_drain_s;
    logic                alu_live_s;
    logic                mul_live_s;
    logic                mul_x0_s;
    sel_t                sel_s;
    logic                pop_s;
    logic                bypass_s;
    logic                push_req_s;
    logic                push_s;
    logic                overflow_s;
    entry_t              head_s;
    entry_t              push_entry_s;
    logic                issue_ok_s;
    logic                issue_err_s;
    logic [CRD_W-1:0]    ret_s;
    logic [CRD_W-1:0]    credit_sum_s;
    logic [CNT_W-1:0]    credit_next_s;
    logic                credit_err_s;
    logic [STV_W-1:0]    starve_next_s;
    logic [CNT_W-1:0]    fifo_cnt_next_s;
    logic                wb_fire_s;
    logic [4:0]          wb_rd_next_s;
    logic [ARCH_LEN-1:0] wb_data_next_s;
    logic                wb_src_next_s;
    logic                proto_err_next_s;

    // Pick this cycle's writeback source and derive FIFO push/pop.
    always_comb begin
        fifo_empty_s  = (fifo_cnt_r == {CNT_W{1'b0}});
        fifo_full_s   = (fifo_cnt_r == DEPTH_C);
        force_drain_s = (starve_cnt_r == LIMIT_C) && !fifo_empty_s;
        alu_live_s    = bus.alu_valid && (bus.alu_rd != 5'd0);
        mul_live_s    = bus.mul_valid && (bus.mul_rd != 5'd0);
        mul_x0_s      = bus.mul_valid && (bus.mul_rd == 5'd0);
        head_s        = mem_r[rd_ptr_r];
        push_entry_s  = '{rd: bus.mul_rd, data: bus.mul_data};

        if (force_drain_s) begin
            sel_s = SEL_DRAIN;
        end else if (alu_live_s) begin
            sel_s = SEL_ALU;
        end else if (!fifo_empty_s) begin
            sel_s = SEL_FIFO;
        end else if (mul_live_s) begin
            sel_s = SEL_BYPASS;
        end else begin
            sel_s = SEL_NONE;
        end

        pop_s      = (sel_s == SEL_DRAIN) || (sel_s == SEL_FIFO);
        bypass_s   = (sel_s == SEL_BYPASS);
        // A non-bypassed, non-x0 multiplier result must be buffered.
        push_req_s = mul_live_s && !bypass_s;
        push_s     = push_req_s && !fifo_full_s;
        overflow_s = push_req_s && fifo_full_s;

        fifo_cnt_next_s = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Next register-file write: winner's payload, or hold address/data when idle.
    always_comb begin
        case (sel_s)
            SEL_DRAIN, SEL_FIFO: begin
                wb_fire_s      = 1'b1;
                wb_rd_next_s   = head_s.rd;
                wb_data_next_s = head_s.data;
                wb_src_next_s  = 1'b1;
            end
            SEL_ALU: begin
                wb_fire_s      = 1'b1;
                wb_rd_next_s   = bus.alu_rd;
                wb_data_next_s = bus.alu_data;
                wb_src_next_s  = 1'b0;
            end
            SEL_BYPASS: begin
                wb_fire_s      = 1'b1;
                wb_rd_next_s   = bus.mul_rd;
                wb_data_next_s = bus.mul_data;
                wb_src_next_s  = 1'b1;
            end
            default: begin
                wb_fire_s      = 1'b0;
                wb_rd_next_s   = wb_rd_r;
                wb_data_next_s = wb_data_r;
                wb_src_next_s  = wb_src_r;
            end
        endcase
    end

    // Credit, starvation and protocol-error next-state logic.
    always_comb begin
        issue_ok_s  = bus.mul_issue && (credit_cnt_r != {CNT_W{1'b0}});
        issue_err_s = bus.mul_issue && (credit_cnt_r == {CNT_W{1'b0}});
        // A FIFO pop and an x0 drop can coincide, returning two credits.
        ret_s        = CRD_W'(pop_s) + CRD_W'(bypass_s) + CRD_W'(mul_x0_s);
        credit_sum_s = {1'b0, credit_cnt_r} + ret_s - CRD_W'(issue_ok_s);

        if (credit_sum_s > DEPTH_EXT_C) begin
            credit_err_s  = 1'b1;
            credit_next_s = DEPTH_C;
        end else begin
            credit_err_s  = 1'b0;
            credit_next_s = credit_sum_s[CNT_W-1:0];
        end

        if (fifo_empty_s || pop_s) begin
            starve_next_s = {STV_W{1'b0}};
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_next_s = starve_cnt_r + STV_W'(1);
        end else begin
            starve_next_s = starve_cnt_r;
        end

        proto_err_next_s = proto_err_r | issue_err_s | credit_err_s | overflow_s;
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_cnt_r <= fifo_cnt_next_s;
        end
    end

    // Credit counter, starvation counter and sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt_r <= DEPTH_C;
            starve_cnt_r <= {STV_W{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            credit_cnt_r <= credit_next_s;
            starve_cnt_r <= starve_next_s;
            proto_err_r  <= proto_err_next_s;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= {ARCH_LEN{1'b0}};
            wb_src_r   <= 1'b0;
        end else begin
            wb_valid_r <= wb_fire_s;
            wb_rd_r    <= wb_rd_next_s;
            wb_data_r  <= wb_data_next_s;
            wb_src_r   <= wb_src_next_s;
        end
    end

    // The stall and ready flags decode registered state only, so they carry
    // no combinational path from this cycle's inputs.
    assign bus.alu_stall       = force_drain_s;
    assign bus.mul_issue_ready = (credit_cnt_r != {CNT_W{1'b0}});
    assign bus.wb_valid        = wb_valid_r;
    assign bus.wb_rd           = wb_rd_r;
    assign bus.wb_data         = wb_data_r;
    assign bus.wb_src          = wb_src_r;
    assign bus.proto_err       = proto_err_r;

endmodule

// File: doc/mul_wb_arbiter.md
Name: mul_wb_arbiter

Overview:
Writeback arbiter between the execute stage and the register-file write port. It merges single-cycle ALU results with results from the 5-stage pipelined multiplier into one registered write port. Multiplier results that lose arbitration are held in an internal FIFO. A credit counter gates multiply issue so the FIFO can never overflow, whatever the number of multiplies in flight.

Parameters:
ARCH_LEN, 32, datapath width (matches constants_pkg).
MUL_FIFO_DEPTH, 8, multiplier result buffer entries and issue credits; power of two, >=2.
STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before the ALU is stalled.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
alu_valid  in  1  ALU result present this cycle.
alu_rd  in  5  ALU destination register.
alu_data  in  ARCH_LEN  ALU result.
alu_stall  out  1  ALU result not consumed this cycle; upstream holds alu_* stable.
mul_issue  in  1  a multiply is entering the multiplier this cycle.
mul_issue_ready  out  1  credit available; mul_issue only legal when high.
mul_valid  in  1  multiplier output valid (reg_data_ready).
mul_rd  in  5  multiplier destination register.
mul_data  in  ARCH_LEN  multiplier dst_reg_data, low ARCH_LEN bits.
wb_valid  out  1  register-file write enable.
wb_rd  out  5  write address.
wb_data  out  ARCH_LEN  write data.
wb_src  out  1  0 = ALU, 1 = MUL (debug/trace).
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty; credit_cnt = MUL_FIFO_DEPTH; starve_cnt = 0.
  - All outputs 0, except mul_issue_ready = 1.
  - Inputs are ignored while rst is low. Reset mid-operation discards buffered and in-flight results; the multiplier is reset by the same rst.
- Outputs wb_* are registered: latency is 1 cycle from the winning input to wb_valid.
- Per-cycle arbitration, in priority order:
  1. Forced drain: starve_cnt == STARVE_LIMIT and FIFO non-empty. alu_stall = 1, computed combinationally from registered state. FIFO head is written back and the ALU input is ignored.
  2. ALU: alu_valid. ALU result is written back.
  3. FIFO: FIFO non-empty. Head is popped and written back.
  4. Bypass: mul_valid and FIFO empty. mul_* is written directly to wb_* (no push).
  5. Otherwise wb_valid = 0 next cycle; wb_rd and wb_data hold their previous values.
- mul_valid not consumed by bypass is pushed to the FIFO tail in the same cycle.
  - Push and pop in the same cycle are legal; occupancy is unchanged and order is preserved.
  - Pushing into a full FIFO sets proto_err; the data is dropped.
- x0 handling:
  - A result with rd == 0 from either source never asserts wb_valid.
  - An ALU x0 result is consumed without using the port; the next priority level is served that cycle.
  - A MUL x0 result is dropped on arrival and never pushed.
- Credits:
  - credit_cnt decrements on mul_issue && mul_issue_ready.
  - A credit is returned when a MUL result leaves via FIFO pop, bypass, or x0 drop.
  - Issue and return in the same cycle leave credit_cnt unchanged.
  - mul_issue_ready = (credit_cnt != 0).
  - mul_issue while not ready sets proto_err and consumes no credit.
  - A return that would take credit_cnt above MUL_FIFO_DEPTH sets proto_err and saturates the count.
- Starvation counter:
  - starve_cnt increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_LIMIT.
  - It clears on any pop, or when the FIFO is empty.
- proto_err is cleared only by reset.
- FIFO pointers are log2(MUL_FIFO_DEPTH) bits and wrap modulo depth. Occupancy is tracked with a separate count of log2(depth)+1 bits, so full and empty are distinguished.

Test Plan:
- Reset then idle: after rst release → wb_valid = 0, mul_issue_ready = 1, credit_cnt = 8, proto_err = 0.
- MUL bypass: mul_valid, rd = 5, data = 0x0000_0015, FIFO empty, no ALU → next cycle wb_valid = 1, wb_rd = 5, wb_data = 0x15, wb_src = 1; credit returned.
- Collision: same cycle ALU (rd = 3, 0xAAAA) and MUL (rd = 7, 0x42) → cycle+1: write rd 3 from ALU; cycle+2: write rd 7 = 0x42 from FIFO.
- Credit exhaustion: issue 8 multiplies with no results → mul_issue_ready = 0 after the 8th. A 9th mul_issue sets proto_err. One MUL writeback restores mul_issue_ready = 1.
- Starvation: FIFO holds 1 entry while alu_valid stays high continuously → after 8 ALU writebacks, alu_stall = 1 for exactly one cycle. That cycle's writeback is the FIFO entry; starve_cnt returns to 0.
- x0 and async reset: MUL rd = 0 → no wb_valid, credit returned. Assert rst low mid-FIFO (3 entries) → outputs zero immediately; after release the FIFO is empty and credit_cnt = 8.
